topk_tracker: RTL
=================

Name: topk_tracker

Overview:
- Streaming top-K tracker: keeps the K most extreme values (largest or smallest) of a valid-qualified sample stream since reset or the last clear, held as a sorted table.
- Parametrised successor of the fixed second-largest tracker: generic width, depth K, ordering mode and signedness, plus a valid qualifier, synchronous clear, rank readout and occupancy count.
- Sits in the stats/monitor path; consumers read any rank or the K-th extreme directly.

Parameters:
- DATA_WIDTH, 32: sample width in bits.
- K, 4: table depth, K >= 2.
- MODE, 0: 0 = track largest (descending table), 1 = track smallest (ascending table).
- SIGNED, 0: 1 = two's-complement comparison, 0 = unsigned.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- clear  input  1  synchronous table flush.
- din_valid  input  1  din is a sample this cycle.
- din  input  DATA_WIDTH  sample.
- rank_sel  input  $clog2(K)  rank to read; 0 = most extreme.
- dout  output  DATA_WIDTH  slot[rank_sel], or 0 if that slot is empty.
- dout_valid  output  1  occ[rank_sel].
- kth_out  output  DATA_WIDTH  slot[K-1], or 0 if empty.
- count  output  $clog2(K+1)  number of occupied slots, 0..K.

Behaviour:
- State: slot[0..K-1] (DATA_WIDTH each) and occ[0..K-1].
  - Invariant: occ is a thermometer code (occ[i] implies occ[i-1]).
  - Occupied slots are sorted: slot[i-1] "better-or-equal" slot[i].
- Reset (resetn low, asynchronous): all slot = 0, all occ = 0, count = 0.
  - Outputs therefore read 0 immediately, without waiting for a clock edge.
  - Reset mid-stream discards all history.
- Compare function better(a,b):
  - MODE 0: a > b. MODE 1: a < b.
  - Signed or unsigned per SIGNED.
  - Strict comparison, so ties insert after existing equal entries (stable).
- Insert on a rising edge with din_valid = 1:
  - wins[i] = !occ[i] || better(din, slot[i]); this vector is monotone.
  - p = lowest i with wins[i].
  - slot[p] <= din, occ[p] <= 1; for i > p: slot[i] <= slot[i-1], occ[i] <= occ[i-1].
  - The previous slot[K-1] falls off the end.
  - No wins (table full and din not better than slot[K-1]): no change.
- Duplicates are kept: inserting a value equal to slot[0] makes it slot[1].
- clear = 1: all occ <= 0 and all slot <= 0.
  - If din_valid is also 1 in the same cycle, the table becomes exactly {din} (slot[0] = din, count = 1).
- din_valid = 0 and clear = 0: state holds.
- Output timing:
  - dout, dout_valid and kth_out are combinational reads of the state registers; rank_sel -> dout is combinational.
  - count is a register updated alongside occ.
  - A sample accepted at edge N is visible on outputs after edge N (one-cycle latency from din to dout).
- Width rules:
  - No arithmetic on data, comparisons only.
  - count increments by 1 on insert while count < K, saturates at K, and clears to 0 (or 1 per the clear+valid rule).
- rank_sel values >= K (only possible when K is not a power of 2): dout = 0, dout_valid = 0.

Decomposition:
- Package topk_pkg:
  - Mode constants TOPK_MAX = 0, TOPK_MIN = 1.
  - Function topk_better(a, b, mode, signed_cmp), shared with the future bottom-K/histogram monitors.
- Sub-module topk_cell: one slot, instantiated K times in a generate loop.
  - Holds slot/occ.
  - Inputs: din, neighbour value/occ from slot i-1, wins from i-1, clear, din_valid.
  - Computes its own wins and chooses hold / load din / shift from neighbour.

Test Plan (DATA_WIDTH = 8, K = 4 unless noted):
- Fill and sort: reset, then push 5, 3, 9, 7 -> slots 9, 7, 5, 3; count = 4; kth_out = 3; rank_sel = 1 gives dout = 7.
- Full-table behaviour: then push 1 -> unchanged; push 8 -> 9, 8, 7, 5 (3 dropped); kth_out = 5.
- Duplicates and hold: then push 9 -> 9, 9, 8, 7; with din_valid = 0 and din = 200 for 3 cycles -> unchanged.
- Clear collision: clear = 1 with din_valid = 1 and din = 4 in the same cycle -> slot[0] = 4, count = 1; rank_sel = 2 gives dout = 0, dout_valid = 0.
- Mode and signedness:
  - MODE = 1: push 5, 3, 9 -> 3, 5, 9; count = 3; kth_out = 0 (slot empty).
  - MODE = 0, SIGNED = 1: push 8'hFF, 8'h01 -> 1, -1.
  - MODE = 0, SIGNED = 0: same pushes -> 255, 1.
- Async reset: drive resetn low between edges with a full table -> dout, kth_out and count read 0 before the next edge.
  - Release resetn, push 6 -> slot[0] = 6, count = 1.

Source files
------------

// File: rtl/topk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : topk_pkg
//  Description : Shared constants and ordering helper for the top-K family of
//                stream monitors (tracker, bottom-K, histogram monitors).
//                  TOPK_MAX    - keep largest values, descending table
//                  TOPK_MIN    - keep smallest values, ascending table
//                  topk_better - strict "a ranks ahead of b" comparison
//  Revision    : 1.0 - initial release
// ============================================================================
package topk_pkg;

    localparam int TOPK_MAX = 0;
    localparam int TOPK_MIN = 1;

    // Operands arrive zero-extended to 64 bits; only the low 'width' bits
    // carry data. For signed ordering the sign bit is inverted, which maps
    // two's complement onto offset binary so a plain unsigned compare gives
    // the signed order.
    function automatic logic topk_better(
        input logic [63:0] a,
        input logic [63:0] b,
        input int          mode,
        input logic        signed_cmp,
        input int          width
    );
        logic [63:0] msk;
        logic [63:0] ua;
        logic [63:0] ub;
        msk = 64'd1 << (width - 1);
        ua  = signed_cmp ? (a ^ msk) : a;
        ub  = signed_cmp ? (b ^ msk) : b;
        return (mode == TOPK_MIN) ? (ua < ub) : (ua > ub);
    endfunction

endpackage
`default_nettype wire

// File: rtl/topk_cell.sv
`default_nettype none
// ============================================================================
//  Module      : topk_cell
//  Description : One slot of the sorted top-K table.
//                  i_nb_slot/i_nb_occ/i_nb_wins - state and win flag of the
//                                                 more-extreme neighbour
//                  o_slot/o_occ                 - this slot's registers
//                  o_wins                       - incoming sample belongs at
//                                                 or ahead of this slot
//                A slot loads the sample when it is the first winner, takes
//                its neighbour's entry when the neighbour also wins (shift
//                down), and otherwise holds.
//  Revision    : 1.0 - initial release
// ============================================================================
module topk_cell
    import topk_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MODE       = TOPK_MAX,
    parameter int SIGNED     = 0,
    parameter bit FIRST      = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_clear,
    input  logic                  i_din_valid,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic [DATA_WIDTH-1:0] i_nb_slot,
    input  logic                  i_nb_occ,
    input  logic                  i_nb_wins,
    output logic [DATA_WIDTH-1:0] o_slot,
    output logic                  o_occ,
    output logic                  o_wins
);

    logic [DATA_WIDTH-1:0] r_slot;
    logic                  r_occ;
    logic                  w_better;

    assign w_better = topk_better(64'(i_din), 64'(r_slot), MODE, (SIGNED != 0), DATA_WIDTH);
    assign o_wins   = !r_occ || w_better;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_slot <= '0;
            r_occ  <= 1'b0;
        end else if (i_clear) begin
            // A sample arriving with clear becomes the only entry, at the head.
            if (i_din_valid && FIRST) begin
                r_slot <= i_din;
                r_occ  <= 1'b1;
            end else begin
                r_slot <= '0;
                r_occ  <= 1'b0;
            end
        end else if (i_din_valid) begin
            // Wins is monotone, so a winning neighbour implies this slot wins.
            if (i_nb_wins) begin
                r_slot <= i_nb_slot;
                r_occ  <= i_nb_occ;
            end else if (o_wins) begin
                r_slot <= i_din;
                r_occ  <= 1'b1;
            end
        end
    end

    assign o_slot = r_slot;
    assign o_occ  = r_occ;

endmodule
`default_nettype wire

// File: rtl/topk_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : topk_tracker
//  Description : Streaming top-K tracker. Keeps the K most extreme samples
//                (largest for MODE 0, smallest for MODE 1) seen since reset
//                or clear, as a sorted table with stable tie ordering.
//                  clk, resetn    - clock, async active-low reset
//                  clear          - synchronous flush (din_valid still loads)
//                  din_valid, din - sample stream
//                  rank_sel       - rank to read, 0 = most extreme
//                  dout/dout_valid- combinational read of slot[rank_sel]
//                  kth_out        - K-th extreme, 0 when not yet filled
//                  count          - occupied slots, 0..K
//  Revision    : 1.0 - initial release
// ============================================================================
module topk_tracker
    import topk_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4,
    parameter int MODE       = TOPK_MAX,
    parameter int SIGNED     = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clear,
    input  logic                   din_valid,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic [$clog2(K)-1:0]   rank_sel,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    output logic [DATA_WIDTH-1:0]  kth_out,
    output logic [$clog2(K+1)-1:0] count
);

    localparam int                 c_rank_w = $clog2(K);
    localparam int                 c_rank_n = 1 << c_rank_w;
    localparam int                 c_cnt_w  = $clog2(K + 1);
    localparam logic [c_cnt_w-1:0] c_k      = c_cnt_w'(K);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

    logic [DATA_WIDTH-1:0] w_slot    [K];
    logic                  w_occ     [K];
    logic                  w_wins    [K];
    logic [DATA_WIDTH-1:0] w_rd_slot [c_rank_n];
    logic                  w_rd_occ  [c_rank_n];
    logic [c_cnt_w-1:0]    r_count;

    genvar gi;
    for (gi = 0; gi < K; gi++) begin : g_cell
        logic [DATA_WIDTH-1:0] w_nb_slot;
        logic                  w_nb_occ;
        logic                  w_nb_wins;

        if (gi == 0) begin : g_head
            assign w_nb_slot = '0;
            assign w_nb_occ  = 1'b0;
            assign w_nb_wins = 1'b0;
        end else begin : g_body
            assign w_nb_slot = w_slot[gi-1];
            assign w_nb_occ  = w_occ[gi-1];
            assign w_nb_wins = w_wins[gi-1];
        end

        topk_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .MODE       (MODE),
            .SIGNED     (SIGNED),
            .FIRST      (gi == 0)
        ) u_cell (
            .clk         (clk),
            .resetn      (resetn),
            .i_clear     (clear),
            .i_din_valid (din_valid),
            .i_din       (din),
            .i_nb_slot   (w_nb_slot),
            .i_nb_occ    (w_nb_occ),
            .i_nb_wins   (w_nb_wins),
            .o_slot      (w_slot[gi]),
            .o_occ       (w_occ[gi]),
            .o_wins      (w_wins[gi])
        );
    end

    // Read table padded to the full rank_sel range; ranks >= K read empty.
    for (gi = 0; gi < c_rank_n; gi++) begin : g_rd
        if (gi < K) begin : g_live
            assign w_rd_slot[gi] = w_occ[gi] ? w_slot[gi] : '0;
            assign w_rd_occ[gi]  = w_occ[gi];
        end else begin : g_pad
            assign w_rd_slot[gi] = '0;
            assign w_rd_occ[gi]  = 1'b0;
        end
    end

    assign dout       = w_rd_slot[rank_sel];
    assign dout_valid = w_rd_occ[rank_sel];
    assign kth_out    = w_occ[K-1] ? w_slot[K-1] : '0;

    // The last slot wins whenever any slot wins (monotone vector), so it
    // doubles as the "sample accepted" flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= din_valid ? c_one : '0;
        end else if (din_valid && w_wins[K-1] && (r_count != c_k)) begin
            r_count <= r_count + c_one;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire
